// File: rtl/bram_line_packer_pkg.sv
// Shared types and constants for the BRAM line packer: pixel/word geometry,
// FSM state encoding and default BRAM sizing.
package bram_line_packer_pkg;

  localparam int PIX_W         = 8;
  localparam int PIX_PER_WORD  = 8;
  localparam int DATA_W        = PIX_W * PIX_PER_WORD;
  localparam int LANE_W        = $clog2(PIX_PER_WORD);
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_NUM_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_line_packer_if.sv
// Pixel stream handshake plus BRAM port A write bus. The master drives pixels
// and observes the BRAM strobe; the slave (the packer) does the opposite.
interface bram_line_packer_if
  import bram_line_packer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_last;
  logic              pix_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (
    output pix_data, pix_valid, pix_last,
    input  pix_ready, ena, wea, addra, dina
  );

  modport slave (
    input  pix_data, pix_valid, pix_last,
    output pix_ready, ena, wea, addra, dina
  );

endinterface

// File: rtl/bram_line_packer_byte_lane_packer.sv
// Byte lane packer: accumulates accepted pixels little-endian into a 64-bit
// word. Lanes above the current one are always zero, so a flushed partial
// word comes out zero-padded without extra masking.
module bram_line_packer_byte_lane_packer
  import bram_line_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              word_full,
  output logic [DATA_W-1:0] packed_word
);

  localparam logic [LANE_W-1:0] LANE_MAX = {LANE_W{1'b1}};

  logic [LANE_W-1:0] lane_r;
  logic [DATA_W-1:0] acc_r;

  // Merge the incoming byte into its lane of the accumulator.
  always_comb begin
    packed_word = acc_r;
    packed_word[{lane_r, 3'b000} +: PIX_W] = pix_data;
  end

  assign word_full = accept & (lane_r == LANE_MAX);

  // Advance the lane on each accept; restart empty once a word is closed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane_r <= '0;
      acc_r  <= '0;
    end else if (clear) begin
      lane_r <= '0;
      acc_r  <= '0;
    end else if (accept) begin
      if ((lane_r == LANE_MAX) || last) begin
        lane_r <= '0;
        acc_r  <= '0;
      end else begin
        lane_r <= lane_r + LANE_W'(1);
        acc_r  <= packed_word;
      end
    end else begin
      lane_r <= lane_r;
      acc_r  <= acc_r;
    end
  end

endmodule

// File: rtl/bram_line_packer.sv
// BRAM line packer top: run-control FSM, BRAM address/word counters and the
// registered port A write strobe. Packs 8 pixels per word, written at
// consecutive addresses from 0; pix_last flushes a partial word.
module bram_line_packer
  import bram_line_packer_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  bram_line_packer_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);

  state_t            state_r;
  logic              ena_r;
  logic [ADDR_W-1:0] addra_r;
  logic [DATA_W-1:0] dina_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W:0]   word_count_r;

  logic              accept_s;
  logic              clear_s;
  logic              word_full_s;
  logic              close_s;
  logic              full_s;
  logic [ADDR_W:0]   words_done_s;
  logic [DATA_W-1:0] packed_s;

  assign accept_s = bus.pix_valid & (state_r == RUN);
  assign clear_s  = start & (state_r == IDLE);

  bram_line_packer_byte_lane_packer u_lanes (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear_s),
    .accept      (accept_s),
    .last        (bus.pix_last),
    .pix_data    (bus.pix_data),
    .word_full   (word_full_s),
    .packed_word (packed_s)
  );

  // Words already committed, counting a strobe still in flight this cycle.
  always_comb begin
    words_done_s = word_count_r + {{ADDR_W{1'b0}}, ena_r};
    close_s      = word_full_s | (accept_s & bus.pix_last);
    full_s       = word_full_s & (words_done_s == LAST_WORD);
  end

  // Run FSM with write strobe, address and word counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      ena_r        <= 1'b0;
      addra_r      <= '0;
      dina_r       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      word_count_r <= '0;
    end else begin
      ena_r  <= 1'b0;
      done_r <= 1'b0;
      if (ena_r) begin
        addra_r      <= addra_r + ADDR_W'(1);
        word_count_r <= word_count_r + (ADDR_W + 1)'(1);
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= RUN;
            addra_r      <= '0;
            word_count_r <= '0;
            busy_r       <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (close_s) begin
            dina_r <= packed_s;
            ena_r  <= 1'b1;
          end
          if (accept_s && (bus.pix_last || full_s)) begin
            state_r <= FINAL;
          end else begin
            state_r <= RUN;
          end
        end
        FINAL: begin
          state_r <= DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready = (state_r == RUN);
  assign bus.ena       = ena_r;
  assign bus.wea       = ena_r;
  assign bus.addra     = addra_r;
  assign bus.dina      = dina_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign word_count    = word_count_r;

endmodule

// File: tb/tb_bram_line_packer.sv
// Bench for bram_line_packer. Two instances share the stimulus: u_dut0 with
// the default 256-word capacity and u_dut1 limited to 2 words for the
// full-stop case. Expected BRAM writes are queued when a test is set up and
// popped whenever a strobe is seen.
module tb_bram_line_packer;
  import bram_line_packer_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        busy0, done0, busy1, done1;
  logic [AW:0] wc0, wc1;

  bram_line_packer_if #(.ADDR_W(AW)) bus0 ();
  bram_line_packer_if #(.ADDR_W(AW)) bus1 ();

  assign bus0.pix_data  = pix_data;
  assign bus0.pix_valid = pix_valid;
  assign bus0.pix_last  = pix_last;
  assign bus1.pix_data  = pix_data;
  assign bus1.pix_valid = pix_valid;
  assign bus1.pix_last  = pix_last;

  bram_line_packer #(.ADDR_W(AW), .NUM_WORDS(256)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus0),
    .busy       (busy0),
    .done       (done0),
    .word_count (wc0)
  );

  bram_line_packer #(.ADDR_W(AW), .NUM_WORDS(2)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus1),
    .busy       (busy1),
    .done       (done1),
    .word_count (wc1)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [71:0] q0[$];
  logic [71:0] q1[$];
  int          acc0 = 0;
  int          acc1 = 0;
  int          done1_cnt = 0;
  bit          mon1_en = 1'b0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobe(input string tag, input logic [71:0] seen, input logic wea, inout logic [71:0] q[$]);
    check({tag, "_wea"}, 72'(wea), 72'(1));
    tests_run++;
    assert (q.size() != 0) else begin
      tests_failed++;
      $error("FAIL %s_unexpected: observed write %0h expected no write", tag, seen);
    end
    if (q.size() != 0) check({tag, "_word"}, seen, q.pop_front());
  endtask

  // One clock: count accepts due at the coming edge, then sample at negedge.
  task automatic tick();
    if (reset_n && pix_valid && bus0.pix_ready) acc0++;
    if (reset_n && pix_valid && bus1.pix_ready) acc1++;
    @(negedge clk);
    if (done1) done1_cnt++;
    if (bus0.ena) check_strobe("strobe0", {bus0.addra, bus0.dina}, bus0.wea, q0);
    if (mon1_en && bus1.ena) check_strobe("strobe1", {bus1.addra, bus1.dina}, bus1.wea, q1);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input bit strict);
    int n;
    pix_data  = d;
    pix_valid = 1'b1;
    pix_last  = l;
    if (strict) check("ready_no_drop", 72'(bus0.pix_ready), 72'(1));
    n = 0;
    while (!bus0.pix_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus0.pix_ready) check("send_timeout", 72'(bus0.pix_ready), 72'(1));
    else tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic do_start(input bit with_pix);
    int a;
    start = 1'b1;
    if (with_pix) begin
      pix_valid = 1'b1;
      pix_data  = 8'hEE;
      pix_last  = 1'b1;
    end
    a = acc0;
    tick();
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    check("start_no_accept", 72'(acc0), 72'(a));
    check("start_busy", 72'(busy0), 72'(1));
  endtask

  // Called at the negedge of the FINAL cycle (right after the last accept).
  task automatic finish_run(input int exp_wc);
    check("final_done", 72'(done0), 72'(0));
    check("final_busy", 72'(busy0), 72'(1));
    tick();
    check("done_pulse", 72'(done0), 72'(1));
    check("done_busy", 72'(busy0), 72'(0));
    check("word_count", 72'(wc0), 72'(exp_wc));
    tick();
    check("done_clear", 72'(done0), 72'(0));
    check("word_count_hold", 72'(wc0), 72'(exp_wc));
  endtask

  task automatic check_reset_vals();
    check("rst_ready", 72'(bus0.pix_ready), 72'(0));
    check("rst_ena", 72'(bus0.ena), 72'(0));
    check("rst_wea", 72'(bus0.wea), 72'(0));
    check("rst_busy", 72'(busy0), 72'(0));
    check("rst_done", 72'(done0), 72'(0));
    check("rst_addra", 72'(bus0.addra), 72'(0));
    check("rst_dina", 72'(bus0.dina), 72'(0));
    check("rst_wc", 72'(wc0), 72'(0));
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    pix_data  = 8'h00;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    tick();
    tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();

    // Full word, pix_last on the 8th pixel.
    q0.push_back({8'h00, 64'h0807060504030201});
    do_start(1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), (i == 8), 1'b1);
    finish_run(1);

    // Streaming three words back-to-back.
    q0.push_back({8'h00, 64'h0706050403020100});
    q0.push_back({8'h01, 64'h0F0E0D0C0B0A0908});
    q0.push_back({8'h02, 64'h1716151413121110});
    do_start(1'b0);
    for (int i = 0; i < 24; i++) send(8'(i), (i == 23), 1'b1);
    finish_run(3);

    // Partial flush.
    q0.push_back({8'h00, 64'h0000000000CCBBAA});
    do_start(1'b0);
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b0, 1'b1);
    send(8'hCC, 1'b1, 1'b1);
    finish_run(1);

    // Stalled stream, pixel in start cycle, stray start mid-run.
    q0.push_back({8'h00, 64'h1817161514131211});
    do_start(1'b1);
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h11 + i), (i == 7), 1'b0);
      if (i < 7) begin
        if (i == 3) start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_busy", 72'(busy0), 72'(1));
        check("stall_addra", 72'(bus0.addra), 72'(0));
      end
    end
    finish_run(1);

    // Reset mid-run after 5 pixels, then a fresh run.
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 1'b0, 1'b1);
    reset_n = 1'b0;
    tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();
    q0.push_back({8'h00, 64'h0000000000005B5A});
    do_start(1'b0);
    send(8'h5A, 1'b0, 1'b1);
    send(8'h5B, 1'b1, 1'b1);
    finish_run(1);

    // Full stop on the 2-word instance; 20 pixels, no pix_last.
    q0.push_back({8'h00, 64'h0706050403020100});
    q0.push_back({8'h01, 64'h0F0E0D0C0B0A0908});
    q1.push_back({8'h00, 64'h0706050403020100});
    q1.push_back({8'h01, 64'h0F0E0D0C0B0A0908});
    mon1_en   = 1'b1;
    acc1      = 0;
    done1_cnt = 0;
    do_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      send(8'(i), 1'b0, 1'b1);
      if (i == 14) check("full_ready_before", 72'(bus1.pix_ready), 72'(1));
      if (i == 15) check("full_ready_after", 72'(bus1.pix_ready), 72'(0));
    end
    repeat (4) tick();
    check("full_accepts", 72'(acc1), 72'(16));
    check("full_done_pulses", 72'(done1_cnt), 72'(1));
    check("full_word_count", 72'(wc1), 72'(2));
    check("full_addra", 72'(bus1.addra), 72'(2));
    check("full_busy", 72'(busy1), 72'(0));
    check("full_writes_left1", 72'(q1.size()), 72'(0));
    check("writes_left0", 72'(q0.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
